// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type, parity constant and byte-parity helper for the SRAM controller
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int PAR_BITS_PER_BYTE = 1;

  // Even parity: the stored bit makes each 9-bit lane carry an even number of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] data);
    logic [3:0] par;
    par = '0;
    for (int b = 0; b < 4; b++) begin
      par[b] = ^data[8*b +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/mem_sram_array.sv
// rtl/mem_sram_array.sv - single-port synchronous read-first word array with per-byte-lane write enables
module mem_sram_array #(
  parameter int WORDS = 1024,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int LW = DW / 4;

  logic [DW-1:0] mem [WORDS];

  // Each byte lane is LW bits wide so parity bits travel with their byte.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[addr][LW*b +: LW] <= wdata[LW*b +: LW];
        end
      end
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - valid/ready SRAM controller with base decode, wait states and range errors; MEM_PARITY_EN adds byte parity
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int          WORDS       = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        busy
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef MEM_PARITY_EN
  localparam int LW = 8 + PAR_BITS_PER_BYTE;
`else
  localparam int LW = 8;
`endif
  localparam int DW = 4 * LW;
  localparam logic [32:0] BASE33  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT33 = BASE33 + (33'(WORDS) << 2);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic          instr_q;
  logic          ready_q, busy_q, range_err_q, data_ok_q;
  logic          accept, do_access, in_range;
  logic [31:0]   offset;
  logic [AW-1:0] widx;
  logic          arr_en;
  logic [3:0]    arr_we;
  logic [DW-1:0] arr_wdata, arr_rdata;
  logic [31:0]   rd_word;
  logic          par_bad;
  logic          unused_bits;

  // 33-bit compare so a window ending at the top of the address space never wraps.
  assign in_range    = ({1'b0, addr_q} >= BASE33) && ({1'b0, addr_q} < LIMIT33);
  assign offset      = addr_q - ADDR_BASE;
  assign widx        = offset[AW+1:2];
  assign unused_bits = ^{instr_q, offset[1:0], offset[31:AW+2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        do_access = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
      data_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= do_access;
      range_err_q <= do_access & ~in_range;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        instr_q <= mem_instr;
        busy_q  <= 1'b1;
      end
      if (do_access) begin
        busy_q    <= 1'b0;
        data_ok_q <= in_range;
      end
    end
  end

  // The array is only touched for in-range accesses, so rejected writes cannot alias.
  assign arr_en = do_access & in_range;
  assign arr_we = wstrb_q & {4{arr_en}};

`ifdef MEM_PARITY_EN
  logic [3:0] wpar, rpar;

  always_comb begin
    arr_wdata = '0;
    rd_word   = '0;
    rpar      = '0;
    wpar      = byte_parity(wdata_q);
    for (int b = 0; b < 4; b++) begin
      arr_wdata[LW*b +: LW] = {wpar[b], wdata_q[8*b +: 8]};
      rd_word[8*b +: 8]     = arr_rdata[LW*b +: 8];
      rpar[b]               = arr_rdata[LW*b + 8];
    end
    par_bad = |(rpar ^ byte_parity(rd_word));
  end
`else
  assign arr_wdata = wdata_q;
  assign rd_word   = arr_rdata;
  assign par_bad   = 1'b0;
`endif

  mem_sram_array #(
    .WORDS (WORDS),
    .DW    (DW),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (widx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Read data comes straight from the array register, masked after resets and range errors.
  assign mem_ready = ready_q;
  assign mem_rdata = data_ok_q ? rd_word : 32'h0;
  assign mem_err   = range_err_q | (ready_q & data_ok_q & par_bad);
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - self-checking bench for mem_sram_ctrl (three configurations, MEM_PARITY_EN section optional)
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  valid;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [2:0]  rdy, err, bsy;
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata;

  longint base_a  [3] = '{64'h0, 64'h1000, 64'hFFFF_FF80};
  int     words_a [3] = '{1024, 16, 37};
  int     ws_a    [3] = '{0, 3, 4};
  logic [31:0] mdl [longint];

  always #5 clk = ~clk;

  mem_sram_ctrl #(.WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0)) u0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[0]), .mem_rdata(rdata[0]),
    .mem_err(err[0]), .busy(bsy[0]));
  mem_sram_ctrl #(.WORDS(16), .ADDR_BASE(32'h1000), .WAIT_STATES(3)) u1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[1]), .mem_rdata(rdata[1]),
    .mem_err(err[1]), .busy(bsy[1]));
  mem_sram_ctrl #(.WORDS(37), .ADDR_BASE(32'hFFFF_FF80), .WAIT_STATES(4)) u2 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[2]), .mem_rdata(rdata[2]),
    .mem_err(err[2]), .busy(bsy[2]));

  function automatic longint mkey(input int u, input longint idx);
    return (longint'(u) << 32) | idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: window decode, read-first old word, byte merge into the stored word.
  task automatic model(input int u, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] exp_rd, output logic exp_err);
    longint aa, lo, hi, k;
    logic [31:0] w;
    aa = longint'({32'h0, a});
    lo = base_a[u];
    hi = lo + 4 * longint'(words_a[u]);
    if (aa >= lo && aa < hi) begin
      k       = mkey(u, (aa - lo) >> 2);
      w       = mdl.exists(k) ? mdl[k] : 32'hx;
      exp_rd  = w;
      exp_err = 1'b0;
      for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      mdl[k] = w;
    end else begin
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end
  endtask

  task automatic txn(input int u, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output logic er, output int cyc, output bit busy_ok);
    addr = a; wdata = wd; wstrb = ws; instr = 1'($urandom); valid[u] = 1'b1;
    @(posedge clk); #1;
    cyc = 1; busy_ok = 1'b1;
    addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    while (!rdy[u] && cyc < 64) begin
      if (!bsy[u]) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    valid[u] = 1'b0;
    rd = rdata[u]; er = err[u];
    if (bsy[u]) busy_ok = 1'b0;
  endtask

  task automatic do_check(input string tag, input int u, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit post);
    logic [31:0] erd, ord;
    logic eer, oer;
    int cyc;
    bit bok;
    model(u, a, wd, ws, erd, eer);
    txn(u, a, wd, ws, ord, oer, cyc, bok);
    if (!$isunknown(erd)) chk({tag, ".rdata"}, ord, erd);
    chk({tag, ".err"}, 32'(oer), 32'(eer));
    chk({tag, ".lat"}, cyc, ws_a[u] + 2);
    last_rdata = ord;
    if (post) begin
      @(posedge clk); #1;
      chk({tag, ".drop"}, 32'({rdy[u], err[u]}), 32'h0);
      chk({tag, ".hold"}, rdata[u], ord);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ord, a;
    logic oer;
    int cyc, u, lim, idx;
    bit bok, saw;

    resetn = 1'b0; valid = '0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(rdy), 32'h0);
    chk("rst.err",   32'(err), 32'h0);
    chk("rst.busy",  32'(bsy), 32'h0);
    chk("rst.rdata", rdata[0], 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      do_check($sformatf("init0_%0d", i), 0, 32'(4 * i), (i == 5) ? 32'hDEAD_BEEF : $urandom, 4'hF, 1);
    for (int i = 0; i < 16; i++)
      do_check($sformatf("init1_%0d", i), 1, 32'h1000 + 32'(4 * i), $urandom, 4'hF, 1);
    for (int i = 0; i < 37; i++)
      do_check($sformatf("init2_%0d", i), 2, 32'hFFFF_FF80 + 32'(4 * i), $urandom, 4'hF, 0);

    do_check("rd14", 0, 32'h14, 32'h0, 4'h0, 1);
    chk("rd14.lit", last_rdata, 32'hDEAD_BEEF);
    do_check("wr14", 0, 32'h14, 32'h1122_3344, 4'b0101, 1);
    chk("wr14.lit", last_rdata, 32'hDEAD_BEEF);
    do_check("rb14", 0, 32'h17, 32'h0, 4'h0, 1);
    chk("rb14.lit", last_rdata, 32'hDE22_BE44);

    txn(1, 32'h1008, 32'h0, 4'h0, ord, oer, cyc, bok);
    chk("ws3.lat", cyc, 5);
    chk("ws3.busy", 32'(bok), 32'h1);
    @(posedge clk); #1;

    do_check("rng.lo",   1, 32'h0FFC, 32'hA5A5_A5A5, 4'hF, 1);
    chk("rng.lo.lit", last_rdata, 32'h0);
    do_check("rng.hi",   1, 32'h1040, 32'h5A5A_5A5A, 4'hF, 1);
    do_check("rng.w0",   1, 32'h1000, 32'h0, 4'h0, 1);
    do_check("rng.last", 1, 32'h103C, 32'h0, 4'h0, 1);
    do_check("wrap.lo",  2, 32'h0000_0010, 32'h1, 4'hF, 1);
    do_check("wrap.top", 2, 32'hFFFF_FFFC, 32'h0, 4'h0, 1);
    do_check("wrap.blw", 2, 32'hFFFF_FF7C, 32'h0, 4'h0, 1);

    do_check("b2b.a", 0, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
    do_check("b2b.b", 0, 32'h20, 32'h0, 4'h0, 1);
    chk("b2b.lit", last_rdata, 32'hCAFE_F00D);

    do_check("mid.pre", 2, 32'hFFFF_FF80, 32'h1234_5678, 4'hF, 1);
    addr = 32'hFFFF_FF80; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid[2] = 1'b0; resetn = 1'b0;
    #1;
    chk("mid.busy", 32'(bsy[2]), 32'h0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy[2]) saw = 1'b1;
      if (i == 2) resetn = 1'b1;
    end
    chk("mid.noready", 32'(saw), 32'h0);
    do_check("mid.rb", 2, 32'hFFFF_FF80, 32'h0, 4'h0, 1);
    chk("mid.lit", last_rdata, 32'h1234_5678);

    for (int i = 0; i < 60; i++) begin
      u   = $urandom_range(0, 2);
      lim = (u == 0) ? 16 : words_a[u];
      idx = $urandom_range(0, lim - 1);
      if ($urandom_range(0, 4) == 0)
        a = ($urandom_range(0, 1) == 1) ? 32'(base_a[u] - 4) : 32'(base_a[u] + 4 * longint'(words_a[u]));
      else
        a = 32'(base_a[u] + 4 * longint'(idx)) | 32'($urandom_range(0, 3));
      do_check($sformatf("rnd%0d", i), u, a, $urandom,
               ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;

`ifdef MEM_PARITY_EN
    begin : parity_check
      logic [35:0] w;
      w = u0.u_array.mem[2];
      w[10] = ~w[10];
      force u0.u_array.mem[2] = w;
      txn(0, 32'h8, 32'h0, 4'h0, ord, oer, cyc, bok);
      chk("par.err", 32'(oer), 32'h1);
      chk("par.rdata", ord, mdl[mkey(0, 2)] ^ 32'h0000_0200);
      release u0.u_array.mem[2];
      @(posedge clk); #1;
      do_check("par.clean", 0, 32'hC, 32'h0, 4'h0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
